// File: rtl/ex_issue.sv
// ex_issue: operand formation and issue register feeding the integer ALU and
// shift unit. Decodes OP / OP-IMM, forms op1/op2 with writeback forwarding,
// and holds up to two entries (main + skid) so backpressure never costs a
// cycle of throughput. Program order is strictly FIFO.
module ex_issue (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [2:0]  funct3_o,
  output logic        funct7_o,
  output logic        shift_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  // src1/src2 hold the register index a held operand may still be refreshed
  // from; 0 means "not register-sourced" (immediate, x0 or illegal), and since
  // a qualifying writeback never targets x0, a zero tag can never match.
  typedef struct packed {
    logic        illegal;
    logic        shift;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [4:0]  src1;
    logic [4:0]  src2;
  } entry_t;

  entry_t      main_q, skid_q;
  entry_t      main_f, skid_f;
  entry_t      new_e;
  logic        main_v, skid_v, rdy_q;
  logic        wb_hit;
  logic        push, pop;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        is_op, is_opi, is_sh;
  logic [31:0] rs1_val, rs2_val;

  assign wb_hit = wb_we_i && (wb_rd_i != 5'd0);
  assign push   = in_valid_i && rdy_q && !flush_i;
  assign pop    = main_v && out_ready_i;

  // Refresh a held entry from this cycle's writeback; shift amounts keep
  // only the low five bits so the shifter never sees an amount above 31.
  function automatic entry_t fwd(input entry_t e, input logic hit,
                                 input logic [4:0] idx, input logic [31:0] d);
    entry_t r;
    r = e;
    if (hit && (e.src1 == idx)) r.op1 = d;
    if (hit && (e.src2 == idx)) r.op2 = e.shift ? {27'b0, d[4:0]} : d;
    return r;
  endfunction

  assign main_f = fwd(main_q, wb_hit, wb_rd_i, wb_data_i);
  assign skid_f = fwd(skid_q, wb_hit, wb_rd_i, wb_data_i);

  // Decode the incoming instruction and form its operands, forwarding the
  // writeback that lands in the same cycle as the register-file read.
  always_comb begin
    opcode  = instr_i[6:0];
    f3      = instr_i[14:12];
    rs1_idx = instr_i[19:15];
    rs2_idx = instr_i[24:20];
    is_op   = (opcode == OPC_OP);
    is_opi  = (opcode == OPC_OPIMM);
    is_sh   = (is_op || is_opi) && ((f3 == 3'b001) || (f3 == 3'b101));

    if (rs1_idx == 5'd0)                    rs1_val = 32'd0;
    else if (wb_hit && wb_rd_i == rs1_idx)  rs1_val = wb_data_i;
    else                                    rs1_val = rs1_data_i;

    if (rs2_idx == 5'd0)                    rs2_val = 32'd0;
    else if (wb_hit && wb_rd_i == rs2_idx)  rs2_val = wb_data_i;
    else                                    rs2_val = rs2_data_i;

    new_e = '0;
    if (is_op || is_opi) begin
      new_e.funct3 = f3;
      new_e.shift  = is_sh;
      new_e.rd     = instr_i[11:7];
      new_e.op1    = rs1_val;
      new_e.src1   = rs1_idx;
      if (is_op) begin
        new_e.funct7 = instr_i[30];
        new_e.op2    = is_sh ? {27'b0, rs2_val[4:0]} : rs2_val;
        new_e.src2   = rs2_idx;
      end else if (is_sh) begin
        new_e.funct7 = instr_i[30];
        new_e.op2    = {27'b0, instr_i[24:20]};
      end else begin
        new_e.op2    = {{20{instr_i[31]}}, instr_i[31:20]};
      end
    end else begin
      // Unknown opcode still issues in order so the trap lands precisely.
      new_e.illegal = 1'b1;
    end
  end

  // Main/skid buffer: flush wins, then pop-with-skid refills main, then
  // an empty-or-draining main takes the new entry, else it lands in skid.
  // rdy_q mirrors !skid_v so in_ready_o comes straight off a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else if (flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      main_q <= main_f;
      skid_q <= skid_f;
      if (pop && skid_v) begin
        main_q <= skid_f;
        skid_v <= 1'b0;
        rdy_q  <= 1'b1;
      end else if (pop || !main_v) begin
        main_v <= push;
        if (push) main_q <= new_e;
      end else if (push) begin
        skid_q <= new_e;
        skid_v <= 1'b1;
        rdy_q  <= 1'b0;
      end
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = main_v;
  assign funct3_o    = main_q.funct3;
  assign funct7_o    = main_q.funct7;
  assign shift_o     = main_q.shift;
  assign op1_o       = main_q.op1;
  assign op2_o       = main_q.op2;
  assign rd_o        = main_q.rd;
  assign illegal_o   = main_q.illegal;

endmodule

// File: tb/tb_ex_issue.sv
// Bench for ex_issue: directed scenarios plus a randomized run checked
// against a queue-based reference model of the issue buffer.
module tb_ex_issue;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] instr, rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [2:0]  funct3;
  logic        funct7, shift;
  logic [31:0] op1, op2;
  logic [4:0]  rd;
  logic        illegal;

  int n_chk = 0;
  int n_pass = 0;

  ex_issue dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .funct3_o(funct3), .funct7_o(funct7), .shift_o(shift),
    .op1_o(op1), .op2_o(op2), .rd_o(rd), .illegal_o(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        illegal;
    logic        shift;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [4:0]  s1;   // register that may still overwrite op1 (0 = none)
    logic [4:0]  s2;
  } exp_t;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rdi, input logic [6:0] opc);
    return {imm, rs1, f3, rdi, opc};
  endfunction

  // Value a source register reads at capture, writeback bypass included.
  function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] data,
      input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && wrd == idx) return wd;
    return data;
  endfunction

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] d1,
      input logic [31:0] d2, input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    exp_t e;
    logic [2:0] f;
    logic sh;
    e = '{default: '0};
    f = ins[14:12];
    sh = (f == 3'd1) || (f == 3'd5);
    if (ins[6:0] == 7'h33) begin
      e.f3 = f; e.shift = sh; e.rd = ins[11:7]; e.f7 = ins[30];
      e.op1 = src_val(ins[19:15], d1, we, wrd, wd);
      e.op2 = src_val(ins[24:20], d2, we, wrd, wd);
      if (sh) e.op2 = e.op2 % 32;
      e.s1 = ins[19:15]; e.s2 = ins[24:20];
    end else if (ins[6:0] == 7'h13) begin
      e.f3 = f; e.shift = sh; e.rd = ins[11:7];
      e.op1 = src_val(ins[19:15], d1, we, wrd, wd);
      e.s1 = ins[19:15];
      if (sh) begin e.op2 = 32'(ins[24:20]); e.f7 = ins[30]; end
      else e.op2 = 32'($signed(ins[31:20]));
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [4:0] r1, r2, rdi;
    sel = $urandom_range(0, 9);
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    rdi = 5'($urandom);
    if (sel == 0) return enc_i(12'($urandom), r1, 3'($urandom), rdi, 7'h03);
    if (sel < 5) return enc_r({1'b0, 1'($urandom), 5'b0}, r2, r1, 3'($urandom), rdi);
    return enc_i(12'($urandom), r1, 3'($urandom), rdi, 7'h13);
  endfunction

  task automatic idle();
    in_valid = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    flush = 1'b0; out_ready = 1'b1; instr = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %0b exp 1", in_ready); else n_pass++;
    n_chk++; if ({op1, op2, rd, funct3, funct7, shift, illegal} !== '0)
      $display("FAIL rst_data got %h/%h/%0d exp all 0", op1, op2, rd); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL post_rst got v%0b r%0b exp v0 r1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_decode();
    @(negedge clk);
    in_valid = 1'b1; instr = 32'h40335293; rs1_data = 32'h80000000; rs2_data = $urandom;
    @(negedge clk);
    instr = enc_r(7'd0, 5'd2, 5'd1, 3'b001, 5'd7); rs1_data = 32'h11; rs2_data = 32'hFFFFFF25;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL srai_valid got %0b exp 1", out_valid); else n_pass++;
    n_chk++; if ({shift, funct3, funct7} !== {1'b1, 3'd5, 1'b1})
      $display("FAIL srai_ctl got sh%0b f3=%0d f7%0b exp sh1 f3=5 f7=1", shift, funct3, funct7); else n_pass++;
    n_chk++; if (op1 !== 32'h80000000 || op2 !== 32'd3 || rd !== 5'd5)
      $display("FAIL srai_ops got %h %h rd%0d exp 80000000 3 rd5", op1, op2, rd); else n_pass++;
    @(negedge clk);
    instr = enc_i(12'hFFF, 5'd3, 3'b000, 5'd4, 7'h13); rs1_data = 32'h42;
    n_chk++; if (op2 !== 32'h5 || shift !== 1'b1 || op1 !== 32'h11)
      $display("FAIL sll_op2 got op2=%h sh%0b exp 5 sh1", op2, shift); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (op2 !== 32'hFFFFFFFF || shift !== 1'b0 || funct7 !== 1'b0 || op1 !== 32'h42)
      $display("FAIL addi_m1 got op2=%h sh%0b f7%0b exp ffffffff 0 0", op2, shift, funct7); else n_pass++;
  endtask

  task automatic test_fwd_capture();
    @(negedge clk);
    in_valid = 1'b1; instr = enc_i(12'd0, 5'd6, 3'b000, 5'd1, 7'h13); rs1_data = 32'hDEAD;
    wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h1234;
    @(negedge clk);
    instr = enc_i(12'd0, 5'd0, 3'b000, 5'd1, 7'h13); rs1_data = 32'h7777;
    wb_rd = 5'd0; wb_data = 32'h5555;
    n_chk++; if (op1 !== 32'h1234) $display("FAIL fwd_x6 got %h exp 1234", op1); else n_pass++;
    @(negedge clk);
    idle();
    n_chk++; if (op1 !== 32'h0) $display("FAIL fwd_x0 got %h exp 0", op1); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] list [4];
    logic [4:0]  got_rd [$];
    logic [31:0] got_op2 [$];
    logic [31:0] exp_op2;
    int idx;
    logic acc;
    for (int i = 0; i < 4; i++) list[i] = enc_r(7'd0, 5'(10 + i), 5'(i + 1), 3'b000, 5'(i + 1));
    idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %0b exp 1", in_ready); else n_pass++;
      end
      if (cyc == 2) begin
        n_chk++; if (in_ready !== 1'b0 || idx != 2)
          $display("FAIL bp_ready2 got r%0b accepts %0d exp r0 accepts 2", in_ready, idx); else n_pass++;
      end
      in_valid = (idx < 4);
      instr = list[(idx < 4) ? idx : 0];
      rs1_data = 32'h1000 + idx;
      rs2_data = 32'h100 + idx;
      out_ready = (cyc >= 3);
      wb_we = (cyc == 2); wb_rd = 5'd11; wb_data = 32'hABC;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin got_rd.push_back(rd); got_op2.push_back(op2); end
      @(posedge clk);
      if (acc) idx++;
    end
    idle();
    n_chk++; if (got_rd.size() != 4) $display("FAIL bp_count got %0d exp 4", got_rd.size()); else n_pass++;
    for (int i = 0; i < got_rd.size() && i < 4; i++) begin
      exp_op2 = (i == 1) ? 32'hABC : 32'h100 + i;
      n_chk++; if (got_rd[i] !== 5'(i + 1) || got_op2[i] !== exp_op2)
        $display("FAIL bp_order%0d got rd%0d op2=%h exp rd%0d op2=%h", i, got_rd[i], got_op2[i], i + 1, exp_op2);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = enc_i(12'd5, 5'd1, 3'b000, 5'd1, 7'h13);
    @(negedge clk);
    instr = enc_i(12'd6, 5'd1, 3'b000, 5'd2, 7'h13);
    @(negedge clk);
    flush = 1'b1; instr = enc_i(12'd7, 5'd1, 3'b000, 5'd3, 7'h13);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_full got v%0b r%0b exp v0 r1", out_valid, in_ready); else n_pass++;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL flush_leak got %0b exp 0", out_valid); else n_pass++;
    // flush while in_ready=1 must still drop the concurrent input
    out_ready = 1'b0; in_valid = 1'b1; instr = enc_i(12'd8, 5'd1, 3'b000, 5'd1, 7'h13);
    @(negedge clk);
    flush = 1'b1; instr = enc_i(12'd9, 5'd1, 3'b000, 5'd3, 7'h13);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1; instr = enc_i(12'd10, 5'd1, 3'b000, 5'd4, 7'h13);
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_rdy1 got v%0b r%0b exp v0 r1", out_valid, in_ready); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || rd !== 5'd4)
      $display("FAIL flush_next got v%0b rd%0d exp v1 rd4", out_valid, rd); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    in_valid = 1'b1; instr = enc_i(12'h123, 5'd3, 3'b010, 5'd5, 7'h03);
    rs1_data = 32'hFFFF; rs2_data = 32'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    n_chk++; if ({out_valid, illegal, shift} !== 3'b110 || op1 !== 0 || op2 !== 0 || rd !== 0)
      $display("FAIL illegal got v%0b il%0b sh%0b %h %h rd%0d exp v1 il1 sh0 0 0 rd0",
               out_valid, illegal, shift, op1, op2, rd); else n_pass++;
  endtask

  task automatic test_reset_stall();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = enc_i(12'd77, 5'd1, 3'b000, 5'd9, 7'h13);
    rs1_data = 32'hCAFE;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || op1 !== 0 || op2 !== 0 || rd !== 0 || illegal !== 0)
      $display("FAIL rst_stall got v%0b r%0b %h %h rd%0d exp v0 r1 0 0 rd0", out_valid, in_ready, op1, op2, rd);
    else n_pass++;
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_stall_after got %0b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    logic do_push, do_pop;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      n_chk++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2))
        $display("FAIL rnd_hs c%0d got v%0b r%0b exp v%0b r%0b", cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
      else n_pass++;
      if (q.size() > 0) begin
        e = q[0];
        n_chk++;
        if ({illegal, shift, op1, op2, rd} !== {e.illegal, e.shift, e.op1, e.op2, e.rd} ||
            (!e.illegal && {funct3, funct7} !== {e.f3, e.f7}))
          $display("FAIL rnd_data c%0d got il%0b sh%0b f3=%0d f7%0b %h %h rd%0d exp il%0b sh%0b f3=%0d f7%0b %h %h rd%0d",
                   cyc, illegal, shift, funct3, funct7, op1, op2, rd,
                   e.illegal, e.shift, e.f3, e.f7, e.op1, e.op2, e.rd);
        else n_pass++;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      instr = rand_instr();
      rs1_data = $urandom; rs2_data = $urandom;
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      flush = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      do_push = in_valid && (q.size() < 2) && !flush;
      do_pop = (q.size() > 0) && out_ready;
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (wb_we && wb_rd != 0)
          foreach (q[i]) begin
            if (q[i].s1 == wb_rd) q[i].op1 = wb_data;
            if (q[i].s2 == wb_rd) q[i].op2 = q[i].shift ? wb_data % 32 : wb_data;
          end
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(model_decode(instr, rs1_data, rs2_data, wb_we, wb_rd, wb_data));
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_decode();
    test_fwd_capture();
    test_backpressure();
    repeat (3) @(negedge clk);
    test_flush();
    test_illegal();
    test_reset_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
